ct_ciu_ctcq_reqq_piu_disp: RTL

Per-target dispatcher for the CTC request queue. It sits directly downstream of the request-queue entry array, with one instance per snoop target (PIU0-3, EBIU, L2C). Each cycle it scans the entries' per-target valid and aim bits, selects one entry and forwards it to the target over a valid/grant handshake. It then pulses that entry's per-target pop, which clears the entry's target-pending bit.

---
 rtl/ct_ciu_ctcq_pkg.sv | 19 +
 rtl/ct_ciu_ctcq_rr_sel.sv | 31 +++
 rtl/ct_ciu_ctcq_reqq_piu_disp.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ct_ciu_ctcq_pkg.sv
// Shared CTC request-queue definitions: dispatcher FSM encoding, entry count and field widths.
`ifndef PA_WIDTH
`define PA_WIDTH 40
`endif

package ct_ciu_ctcq_pkg;

  localparam int unsigned REQQ_ENTRIES = 8;
  localparam int unsigned PA_W         = `PA_WIDTH;
  localparam int unsigned RID_W        = 5;
  localparam int unsigned MID_W        = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_POP  = 2'b10
  } disp_state_e;

endpackage

// File: rtl/ct_ciu_ctcq_rr_sel.sv
// Combinational circular first-set search over the candidate vector, starting at i_start.
module ct_ciu_ctcq_rr_sel #(
  parameter int unsigned ENTRIES = 8,
  parameter int unsigned PTRW    = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] i_cand,
  input  logic [PTRW-1:0]    i_start,
  output logic [ENTRIES-1:0] o_sel_oh_c,
  output logic [PTRW-1:0]    o_sel_idx_c,
  output logic               o_any_c
);

  logic [PTRW-1:0] w_j;

  always_comb begin
    o_sel_oh_c  = '0;
    o_sel_idx_c = '0;
    o_any_c     = 1'b0;
    w_j         = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      // PTRW-bit sum wraps naturally because ENTRIES is a power of two
      w_j = i_start + PTRW'(i);
      if (!o_any_c && i_cand[w_j]) begin
        o_any_c     = 1'b1;
        o_sel_idx_c = w_j;
      end
    end
    o_sel_oh_c[o_sel_idx_c] = o_any_c;
  end

endmodule

// File: rtl/ct_ciu_ctcq_reqq_piu_disp.sv
// Per-target request-queue dispatcher: pick a pending entry, send it over valid/grant, then pop it.
// CIU_CTCQ_DISP_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module ct_ciu_ctcq_reqq_piu_disp
  import ct_ciu_ctcq_pkg::*;
#(
  parameter int unsigned ENTRIES = REQQ_ENTRIES,
  parameter int unsigned PTRW    = $clog2(ENTRIES),
  parameter int unsigned ADDRW   = PA_W
) (
  input  logic                     reqqentyclk,
  input  logic                     cpurst_b,
  input  logic [ENTRIES-1:0]       reqq_tgt_vld,
  input  logic [ENTRIES-1:0]       reqq_tgt_aim,
  input  logic [ENTRIES*ADDRW-1:0] reqq_addr_flat,
  input  logic [ENTRIES*RID_W-1:0] reqq_rid_flat,
  input  logic [ENTRIES*MID_W-1:0] reqq_mid_flat,
  input  logic                     tgt_grant,
  output logic                     disp_req_vld,
  output logic [ADDRW-1:0]         disp_req_addr,
  output logic [RID_W-1:0]         disp_req_rid,
  output logic [MID_W-1:0]         disp_req_mid,
  output logic [PTRW-1:0]          disp_req_ptr,
  output logic [ENTRIES-1:0]       reqq_pop_en,
  output logic                     disp_busy
);

  disp_state_e        r_state;
  logic [PTRW-1:0]    r_ptr;
  logic               r_vld;
  logic [ADDRW-1:0]   r_addr;
  logic [RID_W-1:0]   r_rid;
  logic [MID_W-1:0]   r_mid;

  logic [PTRW-1:0]    w_start;
  logic [ENTRIES-1:0] w_sel_oh;
  logic [PTRW-1:0]    w_sel_idx;
  logic               w_any;
  logic [ADDRW-1:0]   w_sel_addr;
  logic [RID_W-1:0]   w_sel_rid;
  logic [MID_W-1:0]   w_sel_mid;

`ifdef CIU_CTCQ_DISP_RR_EN
  logic [PTRW-1:0]    r_rr_ptr;

  // Round-robin start advances past every entry picked in IDLE
  always_ff @(posedge reqqentyclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rr_ptr <= '0;
    end else if (r_state == ST_IDLE && w_any) begin
      r_rr_ptr <= w_sel_idx + PTRW'(1);
    end
  end

  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  ct_ciu_ctcq_rr_sel #(
    .ENTRIES (ENTRIES),
    .PTRW    (PTRW)
  ) u_sel (
    .i_cand      (reqq_tgt_vld),
    .i_start     (w_start),
    .o_sel_oh_c  (w_sel_oh),
    .o_sel_idx_c (w_sel_idx),
    .o_any_c     (w_any)
  );

  // One-hot AND-OR mux of the selected entry's payload
  always_comb begin
    w_sel_addr = '0;
    w_sel_rid  = '0;
    w_sel_mid  = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (w_sel_oh[i]) begin
        w_sel_addr = w_sel_addr | reqq_addr_flat[i*ADDRW +: ADDRW];
        w_sel_rid  = w_sel_rid  | reqq_rid_flat[i*RID_W +: RID_W];
        w_sel_mid  = w_sel_mid  | reqq_mid_flat[i*MID_W +: MID_W];
      end
    end
  end

  always_ff @(posedge reqqentyclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_vld   <= 1'b0;
      r_addr  <= '0;
      r_rid   <= '0;
      r_mid   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_ptr  <= w_sel_idx;
            r_addr <= w_sel_addr;
            r_rid  <= w_sel_rid;
            r_mid  <= w_sel_mid;
            // Entries not aimed at this target are popped without a request
            r_vld   <= reqq_tgt_aim[w_sel_idx];
            r_state <= reqq_tgt_aim[w_sel_idx] ? ST_SEND : ST_POP;
          end
        end
        ST_SEND: begin
          if (tgt_grant) begin
            r_vld   <= 1'b0;
            r_state <= ST_POP;
          end
        end
        ST_POP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_vld   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign disp_req_vld  = r_vld;
  assign disp_req_addr = r_addr;
  assign disp_req_rid  = r_rid;
  assign disp_req_mid  = r_mid;
  assign disp_req_ptr  = r_ptr;
  assign reqq_pop_en   = (r_state == ST_POP) ? (ENTRIES'(1) << r_ptr) : '0;
  assign disp_busy     = (r_state != ST_IDLE);

endmodule
